// File: rtl/wvb_storage_gen2_pkg.sv
// wvb_storage_gen2_pkg: default sizes and helpers shared by the waveform buffer storage block
package wvb_storage_gen2_pkg;
   localparam int P_DEF_DATA_WIDTH         = 22;
   localparam int P_DEF_ADR_WIDTH          = 12;
   localparam int P_DEF_HDR_WIDTH          = 80;
   localparam int P_DEF_HDR_ADR_WIDTH      = 7;
   localparam int P_DEF_N_WVF_IN_BUF_WIDTH = 16;
   function automatic logic [63:0] f_zext(input logic [63:0] v, input int w);
      return v & ~(64'hFFFF_FFFF_FFFF_FFFF << w);
   endfunction
endpackage

// File: rtl/wvb_hdr_fifo.sv
// wvb_hdr_fifo: synchronous header FIFO with exact count, registered read data and drop/underflow pulses
module wvb_hdr_fifo
   import wvb_storage_gen2_pkg::*;
#(
   parameter int P_WIDTH     = P_DEF_HDR_WIDTH,
   parameter int P_ADR_WIDTH = P_DEF_HDR_ADR_WIDTH
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_wr,
   input  logic [P_WIDTH-1:0]     i_data,
   input  logic                   i_rd,
   output logic [P_WIDTH-1:0]     o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [P_ADR_WIDTH:0]   o_cnt,
   output logic                   o_ovf,
   output logic                   o_udf
);
   localparam logic [P_ADR_WIDTH:0] L_DEPTH = {1'b1, {P_ADR_WIDTH{1'b0}}};
   logic [P_WIDTH-1:0]     r_mem [2**P_ADR_WIDTH];
   logic [P_WIDTH-1:0]     r_data;
   logic [P_ADR_WIDTH-1:0] r_wp, r_rp;
   logic [P_ADR_WIDTH:0]   r_cnt;
   logic                   w_push, w_pop;
   always_comb begin
      o_full  = r_cnt == L_DEPTH;
      o_empty = r_cnt == '0;
      w_pop   = i_rd && !o_empty && !rst;
      w_push  = i_wr && (!o_full || w_pop) && !rst;
      o_ovf   = i_wr && o_full && !w_pop;
      o_udf   = i_rd && o_empty;
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_data;
   // a pop on a full FIFO reads the old slot before the simultaneous push overwrites it
   always_ff @(posedge clk)
      if (rst) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_data <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + P_ADR_WIDTH'(1);
         if (w_pop) begin
            r_rp   <= r_rp + P_ADR_WIDTH'(1);
            r_data <= r_mem[r_rp];
         end
         r_cnt <= r_cnt + (P_ADR_WIDTH+1)'(w_push) - (P_ADR_WIDTH+1)'(w_pop);
      end
   assign o_data = r_data;
   assign o_cnt  = r_cnt;
endmodule

// File: rtl/wvb_storage_gen2.sv
// wvb_storage_gen2: one channel's waveform RAM with word accounting plus header FIFO and sticky overflow flags
module wvb_storage_gen2
   import wvb_storage_gen2_pkg::*;
#(
   parameter int P_DATA_WIDTH         = P_DEF_DATA_WIDTH,
   parameter int P_ADR_WIDTH          = P_DEF_ADR_WIDTH,
   parameter int P_HDR_WIDTH          = P_DEF_HDR_WIDTH,
   parameter int P_HDR_ADR_WIDTH      = P_DEF_HDR_ADR_WIDTH,
   parameter int P_N_WVF_IN_BUF_WIDTH = P_DEF_N_WVF_IN_BUF_WIDTH
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            eoe_in,
   input  logic [P_DATA_WIDTH-1:0]         wvb_data_in,
   input  logic [P_ADR_WIDTH-1:0]          wvb_wr_addr,
   input  logic                            wvb_wrreq,
   input  logic [P_ADR_WIDTH-1:0]          wvb_rd_addr,
   output logic [P_DATA_WIDTH-1:0]         wvb_data_out,
   input  logic                            wvb_free_req,
   input  logic [P_ADR_WIDTH:0]            wvb_free_len,
   output logic [P_ADR_WIDTH:0]            wvb_words_used,
   output logic                            wvb_full,
   input  logic [P_HDR_WIDTH-1:0]          hdr_data_in,
   input  logic                            hdr_wrreq,
   input  logic                            hdr_rdreq,
   output logic [P_HDR_WIDTH-1:0]          hdr_data_out,
   output logic                            hdr_full,
   output logic                            hdr_empty,
   output logic [P_N_WVF_IN_BUF_WIDTH-1:0] n_wvf_in_buf,
   input  logic                            clr_overflow,
   output logic                            wvb_overflow,
   output logic                            hdr_overflow
);
   localparam logic [P_ADR_WIDTH:0] L_DEPTH = {1'b1, {P_ADR_WIDTH{1'b0}}};
   logic [P_DATA_WIDTH-1:0]  r_ram [2**P_ADR_WIDTH];
   logic [P_DATA_WIDTH-1:0]  r_rd_data, w_wdata;
   logic [P_ADR_WIDTH:0]     r_used;
   logic [P_ADR_WIDTH+1:0]   w_sum, w_free;
   logic [P_HDR_ADR_WIDTH:0] w_hdr_cnt;
   logic                     w_wr_ok, w_wr_drop, w_free_udf, w_hdr_ovf, w_hdr_udf, r_wvb_ovf, r_hdr_ovf;
   always_comb begin
      w_wdata    = wvb_data_in;
      w_wdata[0] = eoe_in;
      w_wr_ok    = wvb_wrreq && !wvb_full && !rst;
      w_wr_drop  = wvb_wrreq && wvb_full;
      w_sum      = {1'b0, r_used} + (P_ADR_WIDTH+2)'(w_wr_ok);
      w_free     = wvb_free_req ? {1'b0, wvb_free_len} : '0;
      w_free_udf = w_free > w_sum;
   end
   always_ff @(posedge clk)
      if (w_wr_ok) r_ram[wvb_wr_addr] <= w_wdata;
   // read-first: the registered read sees the pre-write contents of a same-address write
   always_ff @(posedge clk)
      if (rst) begin
         r_rd_data <= '0;
         r_used    <= '0;
         r_wvb_ovf <= 1'b0;
         r_hdr_ovf <= 1'b0;
      end else begin
         r_rd_data <= r_ram[wvb_rd_addr];
         r_used    <= w_free_udf ? '0 : (P_ADR_WIDTH+1)'(w_sum - w_free);
         r_wvb_ovf <= w_wr_drop || w_free_udf || (r_wvb_ovf && !clr_overflow);
         r_hdr_ovf <= w_hdr_ovf || w_hdr_udf || (r_hdr_ovf && !clr_overflow);
      end
   wvb_hdr_fifo #(
      .P_WIDTH     (P_HDR_WIDTH),
      .P_ADR_WIDTH (P_HDR_ADR_WIDTH)
   ) u_hdr_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (hdr_wrreq),
      .i_data  (hdr_data_in),
      .i_rd    (hdr_rdreq),
      .o_data  (hdr_data_out),
      .o_full  (hdr_full),
      .o_empty (hdr_empty),
      .o_cnt   (w_hdr_cnt),
      .o_ovf   (w_hdr_ovf),
      .o_udf   (w_hdr_udf)
   );
   assign wvb_data_out   = r_rd_data;
   assign wvb_words_used = r_used;
   assign wvb_full       = r_used == L_DEPTH;
   assign wvb_overflow   = r_wvb_ovf;
   assign hdr_overflow   = r_hdr_ovf;
   assign n_wvf_in_buf   = P_N_WVF_IN_BUF_WIDTH'(f_zext(64'(w_hdr_cnt), P_HDR_ADR_WIDTH+1));
endmodule

// File: tb/tb_wvb_storage_gen2.sv
// tb_wvb_storage_gen2: directed stimulus checked every cycle against a queue/array model of the storage block
module tb_wvb_storage_gen2;
   localparam int DW = 22, AW = 12, HW = 80, HAW = 7, NW = 16;
   localparam int DEPTH = 4096, HDEPTH = 128;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic          rst, eoe_in, wvb_wrreq, wvb_free_req, hdr_wrreq, hdr_rdreq, clr_overflow;
   logic [DW-1:0] wvb_data_in, wvb_data_out;
   logic [AW-1:0] wvb_wr_addr, wvb_rd_addr;
   logic [AW:0]   wvb_free_len, wvb_words_used;
   logic          wvb_full, hdr_full, hdr_empty, wvb_overflow, hdr_overflow;
   logic [HW-1:0] hdr_data_in, hdr_data_out;
   logic [NW-1:0] n_wvf_in_buf;
   wvb_storage_gen2 #(
      .P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW),
      .P_HDR_ADR_WIDTH(HAW), .P_N_WVF_IN_BUF_WIDTH(NW)
   ) dut (
      .clk(clk), .rst(rst), .eoe_in(eoe_in), .wvb_data_in(wvb_data_in),
      .wvb_wr_addr(wvb_wr_addr), .wvb_wrreq(wvb_wrreq), .wvb_rd_addr(wvb_rd_addr),
      .wvb_data_out(wvb_data_out), .wvb_free_req(wvb_free_req), .wvb_free_len(wvb_free_len),
      .wvb_words_used(wvb_words_used), .wvb_full(wvb_full), .hdr_data_in(hdr_data_in),
      .hdr_wrreq(hdr_wrreq), .hdr_rdreq(hdr_rdreq), .hdr_data_out(hdr_data_out),
      .hdr_full(hdr_full), .hdr_empty(hdr_empty), .n_wvf_in_buf(n_wvf_in_buf),
      .clr_overflow(clr_overflow), .wvb_overflow(wvb_overflow), .hdr_overflow(hdr_overflow)
   );
   int n_chk = 0, n_pass = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_wr [DEPTH];
   logic [HW-1:0] m_q [$];
   int            m_used;
   logic [HW-1:0] m_hdr;
   logic [DW-1:0] m_rd;
   bit            m_rd_vld, m_wovf, m_hovf, chk_en;
   always @(posedge clk) begin
      if (rst) begin
         m_used = 0;
         m_q.delete();
         m_hdr = '0;
         m_rd = '0;
         m_rd_vld = 1;
         m_wovf = 0;
         m_hovf = 0;
      end else begin
         bit full, pop, push, wev, hev;
         int f;
         full = m_used == DEPTH;
         m_rd = m_mem[wvb_rd_addr];
         m_rd_vld = m_wr[wvb_rd_addr];
         if (wvb_wrreq && !full) begin
            m_mem[wvb_wr_addr] = {wvb_data_in[DW-1:1], eoe_in};
            m_wr[wvb_wr_addr] = 1;
            m_used++;
         end
         wev = wvb_wrreq && full;
         f = wvb_free_req ? int'(wvb_free_len) : 0;
         if (f > m_used) begin
            m_used = 0;
            wev = 1;
         end else m_used -= f;
         pop = hdr_rdreq && m_q.size() > 0;
         push = hdr_wrreq && (m_q.size() < HDEPTH || pop);
         hev = (hdr_wrreq && !push) || (hdr_rdreq && !pop);
         if (pop) m_hdr = m_q.pop_front();
         if (push) m_q.push_back(hdr_data_in);
         m_wovf = wev || (m_wovf && !clr_overflow);
         m_hovf = hev || (m_hovf && !clr_overflow);
      end
   end
   always @(negedge clk)
      if (chk_en) begin
         chk("words_used", wvb_words_used, m_used);
         chk("wvb_full", wvb_full, m_used == DEPTH);
         chk("hdr_full", hdr_full, m_q.size() == HDEPTH);
         chk("hdr_empty", hdr_empty, m_q.size() == 0);
         chk("n_wvf_in_buf", n_wvf_in_buf, m_q.size());
         chk("hdr_data_out", hdr_data_out, m_hdr);
         chk("wvb_overflow", wvb_overflow, m_wovf);
         chk("hdr_overflow", hdr_overflow, m_hovf);
         if (m_rd_vld) chk("wvb_data_out", wvb_data_out, m_rd);
      end
   function automatic logic [DW-1:0] dat(input int a);
      return {20'(a) + 20'h100, 2'b10};
   endfunction
   function automatic logic [HW-1:0] hdr(input int i);
      return {16'hC0DE, 64'(i)};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      eoe_in = 0; wvb_wrreq = 0; wvb_free_req = 0; hdr_wrreq = 0; hdr_rdreq = 0; clr_overflow = 0;
   endtask
   task automatic wr(input int a, input bit e);
      wvb_wr_addr = AW'(a);
      wvb_data_in = dat(a);
      eoe_in = e;
      wvb_wrreq = 1;
      tick();
      wvb_wrreq = 0;
      eoe_in = 0;
   endtask
   task automatic push(input int i);
      hdr_data_in = hdr(i);
      hdr_wrreq = 1;
      tick();
      hdr_wrreq = 0;
   endtask
   task automatic pop();
      hdr_rdreq = 1;
      tick();
      hdr_rdreq = 0;
   endtask
   task automatic free(input int n);
      wvb_free_req = 1;
      wvb_free_len = (AW+1)'(n);
      tick();
      wvb_free_req = 0;
   endtask
   task automatic clr();
      clr_overflow = 1;
      tick();
      clr_overflow = 0;
   endtask
   initial begin
      idle();
      rst = 1; wvb_data_in = '0; wvb_wr_addr = '0; wvb_rd_addr = '0; wvb_free_len = '0; hdr_data_in = '0;
      tick();
      chk_en = 1;
      tick();
      rst = 0;
      chk("rst_used", wvb_words_used, 0);
      chk("rst_hdr_empty", hdr_empty, 1);
      chk("rst_dout", wvb_data_out, 0);
      chk("rst_wovf", wvb_overflow, 0);
      for (int a = 0; a < 5; a++) wr(a, a == 4);
      wvb_rd_addr = 4;
      tick();
      chk("rd4_data", wvb_data_out, 22'h413);
      chk("rd4_eoe", wvb_data_out[0], 1);
      chk("used5", wvb_words_used, 5);
      free(5);
      chk("used_after_free", wvb_words_used, 0);
      for (int i = 0; i < 128; i++) push(i);
      chk("hdr_full128", hdr_full, 1);
      chk("n_wvf128", n_wvf_in_buf, 128);
      push(999);
      chk("hdr_ovf_drop", hdr_overflow, 1);
      chk("n_wvf_after_drop", n_wvf_in_buf, 128);
      hdr_data_in = hdr(500); hdr_wrreq = 1; hdr_rdreq = 1;
      tick();
      idle();
      chk("n_wvf_pushpop_full", n_wvf_in_buf, 128);
      chk("oldest_popped", hdr_data_out, 80'hC0DE_0000_0000_0000_0000);
      repeat (128) pop();
      chk("newest_last", hdr_data_out, 80'hC0DE_0000_0000_0000_01F4);
      chk("empty_after_drain", hdr_empty, 1);
      clr();
      chk("clr_hovf", hdr_overflow, 0);
      chk("clr_wovf", wvb_overflow, 0);
      pop();
      chk("underflow_hovf", hdr_overflow, 1);
      chk("underflow_hold", hdr_data_out, 80'hC0DE_0000_0000_0000_01F4);
      clr();
      chk("clr_hovf2", hdr_overflow, 0);
      for (int a = 0; a < DEPTH; a++) wr(a, 0);
      chk("ram_full", wvb_full, 1);
      chk("used4096", wvb_words_used, 4096);
      wvb_wr_addr = 5; wvb_data_in = 22'h3FFFFF; wvb_wrreq = 1;
      tick();
      wvb_wrreq = 0;
      chk("full_write_wovf", wvb_overflow, 1);
      wvb_rd_addr = 5;
      tick();
      chk("ram_unchanged", wvb_data_out, 22'h416);
      clr();
      wvb_wr_addr = 6; wvb_data_in = 22'h3FFFFF; wvb_wrreq = 1; wvb_free_req = 1; wvb_free_len = 10;
      tick();
      idle();
      chk("used_wr_free", wvb_words_used, 4086);
      chk("wr_free_wovf", wvb_overflow, 1);
      chk("not_full", wvb_full, 0);
      clr();
      free(4095);
      chk("free_clamp", wvb_words_used, 0);
      chk("free_udf_wovf", wvb_overflow, 1);
      clr_overflow = 1; wvb_free_req = 1; wvb_free_len = 1;
      tick();
      idle();
      chk("clr_vs_event", wvb_overflow, 1);
      clr();
      chk("clr_wovf2", wvb_overflow, 0);
      for (int i = 0; i < 300; i++) begin
         push(1000 + i);
         pop();
      end
      chk("wrap_empty", hdr_empty, 1);
      chk("wrap_last", hdr_data_out, 80'hC0DE_0000_0000_0000_0513);
      for (int i = 0; i < 3; i++) push(2000 + i);
      for (int a = 0; a < 3; a++) wr(a, 1);
      pop();
      hdr_data_in = hdr(7); hdr_wrreq = 1; wvb_wrreq = 1; hdr_rdreq = 1; rst = 1;
      tick();
      rst = 0;
      idle();
      chk("mid_rst_used", wvb_words_used, 0);
      chk("mid_rst_nwvf", n_wvf_in_buf, 0);
      chk("mid_rst_empty", hdr_empty, 1);
      chk("mid_rst_hdr", hdr_data_out, 0);
      chk("mid_rst_dout", wvb_data_out, 0);
      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
